// File: rtl/pattern_sequencer.sv
// ---------------------------------------------------------------------------
// pattern_sequencer
//   Cycles through NUM_PATTERNS video pattern generators. It advances to the
//   next generator after FRAMES_PER_PATTERN frames, or earlier when the user
//   presses skip. Every switch happens only on a frame boundary, which is the
//   rising edge of the active-low vsync.
//   The block sits between the VGA timing core and the generators. It gates
//   each generator's animation strobe, pulses a restart into the generator it
//   switches to, and muxes that generator's 6-bit RGB onto the output.
//
// Ports
//   clk          pixel clock
//   rst_n        synchronous reset, active low
//   vsync        VGA vsync, active low
//   paused       freezes animation strobes and auto-advance
//   hold         blocks auto-advance only; skip still works
//   skip         level from a debounced button; a rising edge requests next
//   pat_rgb      generator i RGB at [6*i +: 6]
//   rgb          RGB of the active generator
//   pattern_sel  index of the active generator
//   next_frame   per-generator animation strobe (one cycle per frame)
//   pat_rst      per-generator restart, active high
//   frame_cnt    frames elapsed in the current pattern
// ---------------------------------------------------------------------------
module pattern_sequencer #(
  parameter int NUM_PATTERNS       = 3,
  parameter int FRAMES_PER_PATTERN = 300,
  parameter int SEL_W              = 3
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      vsync,
  input  logic                      paused,
  input  logic                      hold,
  input  logic                      skip,
  input  logic [6*NUM_PATTERNS-1:0] pat_rgb,
  output logic [5:0]                rgb,
  output logic [SEL_W-1:0]          pattern_sel,
  output logic [NUM_PATTERNS-1:0]   next_frame,
  output logic [NUM_PATTERNS-1:0]   pat_rst,
  output logic [9:0]                frame_cnt
);

  localparam logic [9:0]       LAST_CNT = 10'(FRAMES_PER_PATTERN - 1);
  localparam logic [SEL_W-1:0] LAST_SEL = SEL_W'(NUM_PATTERNS - 1);

  logic             vsync_q;
  logic             skip_q;
  logic             skip_pending_q, skip_pending_d;
  logic             entry_q, entry_d;
  logic [SEL_W-1:0] sel_q, sel_d;
  logic [9:0]       frame_cnt_q, frame_cnt_d;

  logic vsync_rise;
  logic skip_rise;
  logic advance;

  assign vsync_rise = vsync & ~vsync_q;
  assign skip_rise  = skip & ~skip_q;
  // A pending skip and the terminal count both resolve to a single advance.
  assign advance    = skip_pending_q | (~paused & ~hold & (frame_cnt_q == LAST_CNT));

  always_comb begin
    sel_d          = sel_q;
    frame_cnt_d    = frame_cnt_q;
    skip_pending_d = skip_pending_q;
    entry_d        = 1'b0;
    if (vsync_rise) begin
      if (advance) begin
        sel_d          = (sel_q >= LAST_SEL) ? '0 : sel_q + SEL_W'(1);
        frame_cnt_d    = '0;
        skip_pending_d = 1'b0;
        entry_d        = 1'b1;
      end else if (~paused & ~hold) begin
        frame_cnt_d = frame_cnt_q + 10'd1;
      end
    end
    // Applied last: a skip edge that lands on the boundary cycle is not
    // consumed by it, so it survives to the next boundary.
    if (skip_rise) begin
      skip_pending_d = 1'b1;
    end
  end

  // vsync_q resets high so a reset released while vsync is already high
  // does not fake a frame boundary.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      vsync_q        <= 1'b1;
      skip_q         <= 1'b0;
      skip_pending_q <= 1'b0;
      entry_q        <= 1'b0;
      sel_q          <= '0;
      frame_cnt_q    <= '0;
    end else begin
      vsync_q        <= vsync;
      skip_q         <= skip;
      skip_pending_q <= skip_pending_d;
      entry_q        <= entry_d;
      sel_q          <= sel_d;
      frame_cnt_q    <= frame_cnt_d;
    end
  end

  // The strobe for a newly selected generator starts at the following frame,
  // because sel_q still holds the old index on the switching cycle.
  always_comb begin
    rgb        = 6'b0;
    next_frame = '0;
    pat_rst    = '0;
    for (int i = 0; i < NUM_PATTERNS; i++) begin
      if (sel_q == SEL_W'(i)) begin
        rgb = pat_rgb[6*i +: 6];
      end
      next_frame[i] = vsync_rise & ~paused & (sel_q == SEL_W'(i));
      pat_rst[i]    = ~rst_n | (entry_q & (sel_q == SEL_W'(i)));
    end
  end

  assign pattern_sel = sel_q;
  assign frame_cnt   = frame_cnt_q;

endmodule

// File: tb/tb_pattern_sequencer.sv
// ---------------------------------------------------------------------------
// tb_pattern_sequencer
//   Directed bench for pattern_sequencer with NUM_PATTERNS=3 and
//   FRAMES_PER_PATTERN=4. Inputs are driven on the falling clock edge and
//   outputs are sampled there as well.
// ---------------------------------------------------------------------------
module tb_pattern_sequencer;

  localparam int P = 3;
  localparam int F = 4;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         vsync;
  logic         paused;
  logic         hold;
  logic         skip;
  logic [17:0]  pat_rgb;
  logic [5:0]   rgb;
  logic [2:0]   pattern_sel;
  logic [2:0]   next_frame;
  logic [2:0]   pat_rst;
  logic [9:0]   frame_cnt;

  logic [5:0]   exp_rgb [3];
  logic [2:0]   nf, pr1, pr2;
  int           e_sel, e_cnt;
  int           n_vec = 0;
  int           n_err = 0;

  pattern_sequencer #(
    .NUM_PATTERNS(P),
    .FRAMES_PER_PATTERN(F),
    .SEL_W(3)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .vsync(vsync),
    .paused(paused),
    .hold(hold),
    .skip(skip),
    .pat_rgb(pat_rgb),
    .rgb(rgb),
    .pattern_sel(pattern_sel),
    .next_frame(next_frame),
    .pat_rst(pat_rst),
    .frame_cnt(frame_cnt)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One frame: vsync low for two cycles, then high. Returns next_frame at the
  // rising vsync, and pat_rst one and two cycles after the boundary edge.
  task automatic do_frame(output logic [2:0] nf_o, output logic [2:0] pr1_o,
                          output logic [2:0] pr2_o);
    @(negedge clk); vsync = 1'b0;
    repeat (2) @(negedge clk);
    vsync = 1'b1;
    #1 nf_o = next_frame;
    @(negedge clk); pr1_o = pat_rst;
    @(negedge clk); pr2_o = pat_rst;
  endtask

  task automatic skip_pulse();
    @(negedge clk); skip = 1'b1;
    repeat (2) @(negedge clk);
    skip = 1'b0;
    @(negedge clk);
  endtask

  task automatic check_state(input string tag, input int s, input int c);
    check({tag, "_sel"}, 32'(pattern_sel), 32'(s));
    check({tag, "_cnt"}, 32'(frame_cnt), 32'(c));
    check({tag, "_rgb"}, 32'(rgb), 32'(exp_rgb[s]));
  endtask

  initial begin
    exp_rgb = '{6'h11, 6'h22, 6'h33};
    pat_rgb = {6'h33, 6'h22, 6'h11};
    rst_n = 1'b0; vsync = 1'b1; paused = 1'b0; hold = 1'b0; skip = 1'b0;

    // Reset state
    repeat (3) @(negedge clk);
    check("rst_pat_rst", 32'(pat_rst), 32'h7);
    check_state("rst", 0, 0);
    rst_n = 1'b1;
    @(negedge clk);
    check("rel_pat_rst", 32'(pat_rst), 32'h0);
    check("rel_nf", 32'(next_frame), 32'h0);

    // Free-running: sel 0,1,2,0 every 4 frames, restart pulse into the new one
    e_sel = 0; e_cnt = 0;
    for (int k = 0; k < 12; k++) begin
      do_frame(nf, pr1, pr2);
      check("run_nf", 32'(nf), 32'(1 << e_sel));
      if (e_cnt == F - 1) begin
        e_sel = (e_sel + 1) % P; e_cnt = 0;
        check("run_prst1", 32'(pr1), 32'(1 << e_sel));
      end else begin
        e_cnt++;
        check("run_prst1", 32'(pr1), 32'h0);
      end
      check("run_prst2", 32'(pr2), 32'h0);
      check_state("run", e_sel, e_cnt);
    end
    check_state("run_end", 0, 0);

    // Reach sel=1, frame_cnt=1, then hold for 10 frames
    repeat (5) do_frame(nf, pr1, pr2);
    check_state("pre_hold", 1, 1);
    hold = 1'b1;
    for (int k = 0; k < 10; k++) begin
      do_frame(nf, pr1, pr2);
      check("hold_nf", 32'(nf), 32'h2);
      check_state("hold", 1, 1);
    end
    hold = 1'b0;

    // Skip mid-frame: nothing moves until the next boundary
    skip_pulse();
    repeat (3) @(negedge clk);
    check_state("skip_wait", 1, 1);
    do_frame(nf, pr1, pr2);
    check("skip_nf", 32'(nf), 32'h2);
    check("skip_prst1", 32'(pr1), 32'h4);
    check("skip_prst2", 32'(pr2), 32'h0);
    check_state("skip", 2, 0);

    // Pending skip (two edges) plus terminal count: a single advance
    repeat (3) do_frame(nf, pr1, pr2);
    check_state("pre_term", 2, 3);
    skip_pulse();
    skip_pulse();
    do_frame(nf, pr1, pr2);
    check("term_prst1", 32'(pr1), 32'h1);
    check_state("term", 0, 0);
    do_frame(nf, pr1, pr2);
    check_state("term_next", 0, 1);

    // Skip edge on the same cycle as the vsync rise: deferred one frame
    @(negedge clk); vsync = 1'b0;
    repeat (2) @(negedge clk);
    vsync = 1'b1; skip = 1'b1;
    @(negedge clk);
    skip = 1'b0;
    @(negedge clk);
    check_state("coinc", 0, 2);
    do_frame(nf, pr1, pr2);
    check_state("coinc_next", 1, 0);

    // Paused: no strobes, count frozen, skip still advances
    paused = 1'b1;
    repeat (2) begin
      do_frame(nf, pr1, pr2);
      check("pause_nf", 32'(nf), 32'h0);
      check_state("pause", 1, 0);
    end
    skip_pulse();
    do_frame(nf, pr1, pr2);
    check("pause_skip_nf", 32'(nf), 32'h0);
    check("pause_skip_prst1", 32'(pr1), 32'h4);
    check_state("pause_skip", 2, 0);
    paused = 1'b0;

    // Reset mid-frame with sel=2
    do_frame(nf, pr1, pr2);
    check_state("pre_rst", 2, 1);
    @(negedge clk); vsync = 1'b0;
    @(negedge clk); rst_n = 1'b0; vsync = 1'b1;
    #1 check("mid_rst_comb", 32'(pat_rst), 32'h7);
    @(negedge clk);
    check("mid_rst_prst", 32'(pat_rst), 32'h7);
    check_state("mid_rst", 0, 0);
    rst_n = 1'b1;
    #1 check("post_rst_nf", 32'(next_frame), 32'h0);
    @(negedge clk);
    check_state("post_rst", 0, 0);
    do_frame(nf, pr1, pr2);
    check("post_rst_frame_nf", 32'(nf), 32'h1);
    check_state("post_rst_frame", 0, 1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
